// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM and its ALU function decoder.
// Holds opcodes, state codes, mux-select/ALU-op encodings and the packed control word.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_RTEXEC = 4'd7,
    S_ALUWB  = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_TRAP   = 4'd13
  } state_e;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IOP   = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic [1:0] pcsrc;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       sextend;
    logic       illegal;
    logic       instr_done;
  } ctrl_t;

  // ADDI/SLTI treat the immediate as signed; the logical immediates zero-extend it.
  function automatic logic imm_signed(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_SLTI);
  endfunction

endpackage

// File: rtl/multicycle_outdec.sv
// Moore output decoder for the multi-cycle control FSM: state + latched opcode -> control word.
// Only the FETCH PC/IR loads and the MEMWR completion pulse look at the memory ready strobe.
module multicycle_outdec
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic [STATE_W-1:0] state,
  input  logic [5:0]         op_q,
  input  logic               rdy,
  output ctrl_t              ctrl
);

  logic   in_range;
  state_e st;

  assign in_range = ((state >> 4) == '0);

  always_comb begin
    ctrl = '0;
    st   = state_e'(state[3:0]);
    if (in_range) begin
      case (st)
        S_FETCH: begin
          ctrl.memread = 1'b1;
          ctrl.alusrcb = SRCB_FOUR;
          ctrl.aluop   = ALUOP_ADD;
          ctrl.pcwrite = rdy;
          ctrl.irwrite = rdy;
        end
        S_DECODE: begin
          ctrl.alusrcb = SRCB_IMMSH2;
          ctrl.sextend = 1'b1;
          ctrl.aluop   = ALUOP_ADD;
        end
        S_MEMADR: begin
          ctrl.alusrca = 1'b1;
          ctrl.alusrcb = SRCB_IMM;
          ctrl.sextend = 1'b1;
        end
        S_MEMRD: begin
          ctrl.iord    = 1'b1;
          ctrl.memread = 1'b1;
        end
        S_MEMWB: begin
          ctrl.memtoreg   = 1'b1;
          ctrl.regwrite   = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_MEMWR: begin
          ctrl.iord       = 1'b1;
          ctrl.memwrite   = 1'b1;
          ctrl.instr_done = rdy;
        end
        S_RTEXEC: begin
          ctrl.alusrca = 1'b1;
          ctrl.alusrcb = SRCB_RT;
          ctrl.aluop   = ALUOP_FUNCT;
        end
        S_ALUWB: begin
          ctrl.regdst     = 1'b1;
          ctrl.regwrite   = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_IEXEC: begin
          ctrl.alusrca = 1'b1;
          ctrl.alusrcb = SRCB_IMM;
          ctrl.aluop   = ALUOP_IOP;
          ctrl.sextend = imm_signed(op_q);
        end
        S_IWB: begin
          ctrl.regwrite   = 1'b1;
          ctrl.instr_done = 1'b1;
          ctrl.sextend    = imm_signed(op_q);
        end
        S_BRANCH: begin
          ctrl.alusrca    = 1'b1;
          ctrl.alusrcb    = SRCB_RT;
          ctrl.aluop      = ALUOP_SUB;
          ctrl.branch     = 1'b1;
          ctrl.pcsrc      = PCSRC_ALUOUT;
          ctrl.instr_done = 1'b1;
        end
        S_JUMP: begin
          ctrl.pcwrite    = 1'b1;
          ctrl.pcsrc      = PCSRC_JUMP;
          ctrl.instr_done = 1'b1;
        end
        S_TRAP: begin
          ctrl.illegal    = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        default: ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath: state register, opcode latch and
// next-state logic; all datapath controls come from multicycle_outdec.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int STATE_W       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       branch,
  output logic [1:0] pcsrc,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       sextend,
  output logic       illegal,
  output logic       instr_done
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [5:0]         op_q;
  logic               rdy;
  logic               in_range;
  state_e             st;
  ctrl_t              ctrl;

  assign rdy      = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign in_range = ((state_q >> 4) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STATE_W'(S_RESET);
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (in_range && (state_q[3:0] == S_DECODE))
        op_q <= op;
    end
  end

  // Unused or out-of-range encodings fall back to FETCH.
  always_comb begin
    state_d = STATE_W'(S_FETCH);
    st      = state_e'(state_q[3:0]);
    if (in_range) begin
      case (st)
        S_FETCH: state_d = rdy ? STATE_W'(S_DECODE) : STATE_W'(S_FETCH);
        S_DECODE: begin
          case (op)
            OP_RTYPE:                                  state_d = STATE_W'(S_RTEXEC);
            OP_LW, OP_SW:                              state_d = STATE_W'(S_MEMADR);
            OP_BEQ:                                    state_d = STATE_W'(S_BRANCH);
            OP_J:                                      state_d = STATE_W'(S_JUMP);
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: state_d = STATE_W'(S_IEXEC);
            default:                                   state_d = STATE_W'(S_TRAP);
          endcase
        end
        S_MEMADR: state_d = (op_q == OP_LW) ? STATE_W'(S_MEMRD) : STATE_W'(S_MEMWR);
        S_MEMRD:  state_d = rdy ? STATE_W'(S_MEMWB) : STATE_W'(S_MEMRD);
        S_MEMWR:  state_d = rdy ? STATE_W'(S_FETCH) : STATE_W'(S_MEMWR);
        S_RTEXEC: state_d = STATE_W'(S_ALUWB);
        S_IEXEC:  state_d = STATE_W'(S_IWB);
        default:  state_d = STATE_W'(S_FETCH);
      endcase
    end
  end

  multicycle_outdec #(
    .STATE_W (STATE_W)
  ) u_outdec (
    .state (state_q),
    .op_q  (op_q),
    .rdy   (rdy),
    .ctrl  (ctrl)
  );

  assign pcwrite    = ctrl.pcwrite;
  assign branch     = ctrl.branch;
  assign pcsrc      = ctrl.pcsrc;
  assign iord       = ctrl.iord;
  assign memread    = ctrl.memread;
  assign memwrite   = ctrl.memwrite;
  assign irwrite    = ctrl.irwrite;
  assign regdst     = ctrl.regdst;
  assign memtoreg   = ctrl.memtoreg;
  assign regwrite   = ctrl.regwrite;
  assign alusrca    = ctrl.alusrca;
  assign alusrcb    = ctrl.alusrcb;
  assign aluop      = ctrl.aluop;
  assign sextend    = ctrl.sextend;
  assign illegal    = ctrl.illegal;
  assign instr_done = ctrl.instr_done;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the driver queues the expected control word for
// each cycle, the monitor pops and compares at the falling edge.
module tb_multicycle_control;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic [1:0] pcsrc;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       sextend;
    logic       illegal;
    logic       instr_done;
  } exp_t;

  typedef struct {
    exp_t  v;
    string name;
  } item_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = 6'd0;
  logic       mem_ready = 1'b1;
  logic       pcwrite, branch, iord, memread, memwrite, irwrite, regdst, memtoreg;
  logic       regwrite, alusrca, sextend, illegal, instr_done;
  logic [1:0] pcsrc, alusrcb, aluop;

  item_t expq[$];
  int    vectors = 0;
  int    miscompares = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .branch(branch), .pcsrc(pcsrc), .iord(iord),
    .memread(memread), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .aluop(aluop), .sextend(sextend), .illegal(illegal), .instr_done(instr_done)
  );

  // Expected control words per state, written out from the state table.
  function automatic exp_t e_zero();
    return '0;
  endfunction
  function automatic exp_t e_fetch(input logic rdy);
    exp_t e = '0;
    e.memread = 1; e.alusrcb = 2'b01; e.pcwrite = rdy; e.irwrite = rdy;
    return e;
  endfunction
  function automatic exp_t e_decode();
    exp_t e = '0;
    e.alusrcb = 2'b11; e.sextend = 1;
    return e;
  endfunction
  function automatic exp_t e_memadr();
    exp_t e = '0;
    e.alusrca = 1; e.alusrcb = 2'b10; e.sextend = 1;
    return e;
  endfunction
  function automatic exp_t e_memrd();
    exp_t e = '0;
    e.iord = 1; e.memread = 1;
    return e;
  endfunction
  function automatic exp_t e_memwb();
    exp_t e = '0;
    e.memtoreg = 1; e.regwrite = 1; e.instr_done = 1;
    return e;
  endfunction
  function automatic exp_t e_memwr(input logic rdy);
    exp_t e = '0;
    e.iord = 1; e.memwrite = 1; e.instr_done = rdy;
    return e;
  endfunction
  function automatic exp_t e_rtexec();
    exp_t e = '0;
    e.alusrca = 1; e.aluop = 2'b10;
    return e;
  endfunction
  function automatic exp_t e_aluwb();
    exp_t e = '0;
    e.regdst = 1; e.regwrite = 1; e.instr_done = 1;
    return e;
  endfunction
  function automatic exp_t e_iexec(input logic sx);
    exp_t e = '0;
    e.alusrca = 1; e.alusrcb = 2'b10; e.aluop = 2'b11; e.sextend = sx;
    return e;
  endfunction
  function automatic exp_t e_iwb(input logic sx);
    exp_t e = '0;
    e.regwrite = 1; e.instr_done = 1; e.sextend = sx;
    return e;
  endfunction
  function automatic exp_t e_branch();
    exp_t e = '0;
    e.alusrca = 1; e.aluop = 2'b01; e.branch = 1; e.pcsrc = 2'b01; e.instr_done = 1;
    return e;
  endfunction
  function automatic exp_t e_jump();
    exp_t e = '0;
    e.pcwrite = 1; e.pcsrc = 2'b10; e.instr_done = 1;
    return e;
  endfunction
  function automatic exp_t e_trap();
    exp_t e = '0;
    e.illegal = 1; e.instr_done = 1;
    return e;
  endfunction

  // Drive one cycle's inputs just after the rising edge and queue what that cycle must show.
  task automatic applyStimulus(input logic r, input logic [5:0] o, input logic rdy,
                               input exp_t e, input string name);
    item_t it;
    rst_n     = r;
    op        = o;
    mem_ready = rdy;
    it.v      = e;
    it.name   = name;
    expq.push_back(it);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput();
    item_t it;
    exp_t  act;
    act = {pcwrite, branch, pcsrc, iord, memread, memwrite, irwrite, regdst, memtoreg,
           regwrite, alusrca, alusrcb, aluop, sextend, illegal, instr_done};
    it = expq.pop_front();
    vectors++;
    if (act !== it.v) begin
      miscompares++;
      $display("[TB] FAIL %s: got %05h expected %05h", it.name, act, it.v);
    end
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) checkOutput();
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    // Reset and release
    applyStimulus(0, 6'd0, 1, e_zero(), "reset");
    applyStimulus(1, 6'd0, 1, e_zero(), "reset_release");
    // R-type, with a stalled fetch first
    applyStimulus(1, 6'd0, 0, e_fetch(0), "r_fetch_wait");
    applyStimulus(1, 6'd0, 1, e_fetch(1), "r_fetch");
    applyStimulus(1, 6'b000000, 1, e_decode(), "r_decode");
    applyStimulus(1, 6'd0, 1, e_rtexec(), "r_exec");
    applyStimulus(1, 6'd0, 1, e_aluwb(), "r_wb");
    // LW with two memory wait cycles in MEMRD
    applyStimulus(1, 6'd0, 1, e_fetch(1), "lw_fetch");
    applyStimulus(1, 6'b100011, 1, e_decode(), "lw_decode");
    applyStimulus(1, 6'd0, 1, e_memadr(), "lw_memadr");
    applyStimulus(1, 6'd0, 0, e_memrd(), "lw_memrd_w1");
    applyStimulus(1, 6'd0, 0, e_memrd(), "lw_memrd_w2");
    applyStimulus(1, 6'd0, 1, e_memrd(), "lw_memrd");
    applyStimulus(1, 6'd0, 1, e_memwb(), "lw_memwb");
    // ORI (zero extend), op changed during execute must be ignored
    applyStimulus(1, 6'd0, 1, e_fetch(1), "ori_fetch");
    applyStimulus(1, 6'b001101, 1, e_decode(), "ori_decode");
    applyStimulus(1, 6'b001000, 1, e_iexec(0), "ori_iexec");
    applyStimulus(1, 6'b001000, 1, e_iwb(0), "ori_iwb");
    // ADDI (sign extend)
    applyStimulus(1, 6'd0, 1, e_fetch(1), "addi_fetch");
    applyStimulus(1, 6'b001000, 1, e_decode(), "addi_decode");
    applyStimulus(1, 6'b001101, 1, e_iexec(1), "addi_iexec");
    applyStimulus(1, 6'd0, 1, e_iwb(1), "addi_iwb");
    // SW with one wait cycle
    applyStimulus(1, 6'd0, 1, e_fetch(1), "sw_fetch");
    applyStimulus(1, 6'b101011, 1, e_decode(), "sw_decode");
    applyStimulus(1, 6'd0, 1, e_memadr(), "sw_memadr");
    applyStimulus(1, 6'd0, 0, e_memwr(0), "sw_memwr_wait");
    applyStimulus(1, 6'd0, 1, e_memwr(1), "sw_memwr");
    // BEQ and J
    applyStimulus(1, 6'd0, 1, e_fetch(1), "beq_fetch");
    applyStimulus(1, 6'b000100, 1, e_decode(), "beq_decode");
    applyStimulus(1, 6'd0, 1, e_branch(), "beq_branch");
    applyStimulus(1, 6'd0, 1, e_fetch(1), "j_fetch");
    applyStimulus(1, 6'b000010, 1, e_decode(), "j_decode");
    applyStimulus(1, 6'd0, 1, e_jump(), "j_jump");
    // Illegal opcodes
    applyStimulus(1, 6'd0, 1, e_fetch(1), "ill_fetch");
    applyStimulus(1, 6'b111111, 1, e_decode(), "ill_decode");
    applyStimulus(1, 6'd0, 1, e_trap(), "ill_trap");
    applyStimulus(1, 6'd0, 1, e_fetch(1), "jal_fetch");
    applyStimulus(1, 6'b000011, 1, e_decode(), "jal_decode");
    applyStimulus(1, 6'd0, 1, e_trap(), "jal_trap");
    // Reset asserted while a store is waiting in MEMWR
    applyStimulus(1, 6'd0, 1, e_fetch(1), "rst_fetch");
    applyStimulus(1, 6'b101011, 1, e_decode(), "rst_decode");
    applyStimulus(1, 6'd0, 1, e_memadr(), "rst_memadr");
    applyStimulus(1, 6'd0, 0, e_memwr(0), "rst_memwr");
    applyStimulus(0, 6'd0, 0, e_zero(), "rst_abort");
    applyStimulus(1, 6'd0, 1, e_zero(), "rst_restart");
    applyStimulus(1, 6'd0, 1, e_fetch(1), "rst_fetch_again");
    @(negedge clk);
    #1;
    if (expq.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
